// File: rtl/bram_strobe.sv
// Simple dual-port word memory with byte-lane write strobes, selectable read-during-write
// behaviour, optional output register and a zero-fill engine that runs after reset or on request.
module bram_strobe #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_MODE    = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLEAR_REQ,
    input  logic [ADDR_WIDTH-1:0]   W_ADDR,
    input  logic                    WRITE_EN,
    input  logic [DATA_WIDTH/8-1:0] W_STRB,
    input  logic [DATA_WIDTH-1:0]   DIN,
    input  logic [ADDR_WIDTH-1:0]   R_ADDR,
    input  logic                    READ_EN,
    output logic [DATA_WIDTH-1:0]   DOUT,
    output logic                    DOUT_VALID,
    output logic                    BUSY
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   next_cnt;
    logic                    clearing;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            CLEAR: begin
                next_cnt = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (CLEAR_REQ) begin
                    next_state = CLEAR;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = CLEAR;
                next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        BUSY     = (state == CLEAR);
        clearing = (state == CLEAR) && !RST;
        wr_fire  = (state == RUN) && !RST && WRITE_EN;
        rd_fire  = (state == RUN) && !RST && READ_EN;
    end

    // The array itself carries no reset so it can map onto block RAM; the clear engine defines it.
    always_ff @(posedge CLK) begin
        if (clearing) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (W_STRB[i]) begin
                    mem[W_ADDR][8*i +: 8] <= DIN[8*i +: 8];
                end
            end
        end
    end

    // Write-first mode forwards the strobed lanes of a same-address write into the read word.
    always_comb begin
        rd_word = mem[R_ADDR];
        if (RD_MODE == 1 && wr_fire && (W_ADDR == R_ADDR)) begin
            for (int i = 0; i < LANES; i++) begin
                if (W_STRB[i]) begin
                    rd_word[8*i +: 8] = DIN[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_data;
            logic                  out_valid;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    out_data  <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= rd_valid;
                    if (rd_valid) begin
                        out_data <= rd_data;
                    end
                end
            end

            assign DOUT       = out_data;
            assign DOUT_VALID = out_valid;
        end else begin : g_no_out_reg
            assign DOUT       = rd_data;
            assign DOUT_VALID = rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_bram_strobe.sv
// Scoreboard bench for bram_strobe: a read-first/unregistered and a write-first/registered
// instance share stimulus; each has its own expected-data queue and monitor.
module tb_bram_strobe;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic [3:0]  w_addr;
    logic        write_en;
    logic [3:0]  w_strb;
    logic [31:0] din;
    logic [3:0]  r_addr;
    logic        read_en;

    logic [31:0] dout0;
    logic        dout_valid0;
    logic        busy0;
    logic [31:0] dout1;
    logic        dout_valid1;
    logic        busy1;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          vectors;
    int          miscompares;

    bram_strobe #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .RD_MODE   (0),
        .OUT_REG   (0)
    ) dut0 (
        .CLK       (clk),
        .RST       (rst),
        .CLEAR_REQ (clear_req),
        .W_ADDR    (w_addr),
        .WRITE_EN  (write_en),
        .W_STRB    (w_strb),
        .DIN       (din),
        .R_ADDR    (r_addr),
        .READ_EN   (read_en),
        .DOUT      (dout0),
        .DOUT_VALID(dout_valid0),
        .BUSY      (busy0)
    );

    bram_strobe #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .RD_MODE   (1),
        .OUT_REG   (1)
    ) dut1 (
        .CLK       (clk),
        .RST       (rst),
        .CLEAR_REQ (clear_req),
        .W_ADDR    (w_addr),
        .WRITE_EN  (write_en),
        .W_STRB    (w_strb),
        .DIN       (din),
        .R_ADDR    (r_addr),
        .READ_EN   (read_en),
        .DOUT      (dout1),
        .DOUT_VALID(dout_valid1),
        .BUSY      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [3:0] strb,
                                 input logic [31:0] wd, input logic re, input logic [3:0] ra,
                                 input logic clr);
        write_en  = we;
        w_addr    = wa;
        w_strb    = strb;
        din       = wd;
        read_en   = re;
        r_addr    = ra;
        clear_req = clr;
        tick();
        write_en  = 1'b0;
        read_en   = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic writeWord(input logic [3:0] wa, input logic [3:0] strb, input logic [31:0] wd);
        applyStimulus(1'b1, wa, strb, wd, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic readExpect(input logic [3:0] ra, input logic [31:0] exp0, input logic [31:0] exp1);
        q0.push_back(exp0);
        q1.push_back(exp1);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, ra, 1'b0);
    endtask

    // Counts BUSY cycles over a fixed window; optionally hammers writes/reads at addr 0 while busy.
    task automatic checkClear(input string tag, input bit poke);
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        for (int j = 0; j < 24; j++) begin
            n0 += int'(busy0);
            n1 += int'(busy1);
            write_en = poke && busy0 && busy1;
            read_en  = poke && busy0 && busy1;
            w_addr   = 4'd0;
            r_addr   = 4'd0;
            w_strb   = 4'hF;
            din      = 32'hDEADBEEF;
            tick();
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        checkOutput({tag, " busy cycles dut0"}, 32'(n0), 32'd16);
        checkOutput({tag, " busy cycles dut1"}, 32'(n1), 32'd16);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " dout0"}, dout0, 32'h0);
        checkOutput({tag, " valid0"}, {31'b0, dout_valid0}, 32'h0);
        checkOutput({tag, " busy0"}, {31'b0, busy0}, 32'h1);
        checkOutput({tag, " dout1"}, dout1, 32'h0);
        checkOutput({tag, " valid1"}, {31'b0, dout_valid1}, 32'h0);
        checkOutput({tag, " busy1"}, {31'b0, busy1}, 32'h1);
    endtask

    always @(negedge clk) begin
        if (dout_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 spurious valid", {31'b0, dout_valid0}, 32'h0);
            end else begin
                checkOutput("dut0 read data", dout0, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (dout_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 spurious valid", {31'b0, dout_valid1}, 32'h0);
            end else begin
                checkOutput("dut1 read data", dout1, q1.pop_front());
            end
        end
    end

    initial begin
        logic [5:0] v0;
        logic [5:0] v1;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clear_req   = 1'b0;
        write_en    = 1'b0;
        read_en     = 1'b0;
        w_addr      = 4'd0;
        r_addr      = 4'd0;
        w_strb      = 4'h0;
        din         = 32'h0;

        // Reset then full clear; every word reads back as zero.
        tick();
        checkResetState("reset");
        tick();
        tick();
        rst = 1'b0;
        checkClear("initial clear", 1'b0);
        for (int a = 0; a < 16; a++) begin
            readExpect(4'(a), 32'h0, 32'h0);
        end
        idle(2);

        // Byte strobes.
        writeWord(4'd5, 4'hF, 32'h11223344);
        writeWord(4'd5, 4'b0101, 32'hAABBCCDD);
        readExpect(4'd5, 32'h11BB33DD, 32'h11BB33DD);
        writeWord(4'd5, 4'h0, 32'hFFFFFFFF);
        readExpect(4'd5, 32'h11BB33DD, 32'h11BB33DD);
        idle(2);

        // Same-address collision: old word in read-first, merged word in write-first.
        q0.push_back(32'h00000000);
        q1.push_back(32'hCAFEF00D);
        applyStimulus(1'b1, 4'd3, 4'hF, 32'hCAFEF00D, 1'b1, 4'd3, 1'b0);
        readExpect(4'd3, 32'hCAFEF00D, 32'hCAFEF00D);
        idle(2);

        // Back-to-back reads: latency 1 edge for dut0, 2 edges for dut1, no bubbles.
        for (int a = 1; a <= 4; a++) begin
            writeWord(4'(a), 4'hF, 32'h10 + 32'(a - 1));
        end
        idle(2);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                readExpect(4'(i + 1), 32'h10 + 32'(i), 32'h10 + 32'(i));
            end else begin
                idle(1);
            end
            v0[i] = dout_valid0;
            v1[i] = dout_valid1;
        end
        checkOutput("dut0 valid pattern", {26'b0, v0}, 32'h0F);
        checkOutput("dut1 valid pattern", {26'b0, v1}, 32'h1E);
        idle(2);

        // Clear request with a same-cycle read; requests during the clear are ignored.
        writeWord(4'd2, 4'hF, 32'h12);
        q0.push_back(32'h12);
        q1.push_back(32'h12);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b1);
        checkClear("clear request", 1'b1);
        readExpect(4'd0, 32'h0, 32'h0);
        readExpect(4'd2, 32'h0, 32'h0);
        idle(2);

        // Reset while a registered read is in flight, then reset again mid-clear.
        writeWord(4'd9, 4'hF, 32'h5A5A5A5A);
        q0.push_back(32'h5A5A5A5A);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9, 1'b0);
        rst = 1'b1;
        tick();
        checkResetState("reset mid-read");
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        checkResetState("reset mid-clear");
        rst = 1'b0;
        checkClear("restarted clear", 1'b0);
        readExpect(4'd9, 32'h0, 32'h0);
        idle(4);

        checkOutput("dut0 queue drained", 32'(q0.size()), 32'h0);
        checkOutput("dut1 queue drained", 32'(q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
